// File: rtl/pipe_pkg.sv
// Shared pipeline types: FSM state, scoreboard entry and register-number constants
// used by the hazard controller and its comparator.
package pipe_pkg;

    localparam int unsigned REG_W = 32'd5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic             wr;
        logic [REG_W-1:0] dst;
        logic             load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{wr: 1'b0, dst: REG_ZERO, load: 1'b0};

    function automatic sb_entry_t make_entry(input logic vld_i, input logic rwe_i,
                                             input logic [REG_W-1:0] dst_i, input logic load_i);
        sb_entry_t e;
        e.wr   = vld_i & rwe_i;
        e.dst  = dst_i;
        e.load = vld_i & load_i;
        return e;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side inputs and hazard/bypass outputs of the hazard controller,
// bundled as one interface; master is the pipeline side, slave is hazard_ctrl.
interface hazard_ctrl_if;
    import pipe_pkg::*;

    logic             d_valid;
    logic             d_uses_rs;
    logic             d_uses_rt;
    logic [REG_W-1:0] d_rs;
    logic [REG_W-1:0] d_rt;
    logic [REG_W-1:0] d_dst;
    logic             d_rwe;
    logic             d_load;
    logic             x_branch_taken;
    logic             stall_fd;
    logic             flush_fd;
    logic             bubble_x;
    logic             mx_abypass;
    logic             mx_bbypass;
    logic             wx_abypass;
    logic             wx_bbypass;
    logic [31:0]      stall_cnt;
    logic [31:0]      flush_cnt;

    modport master (
        output d_valid, d_uses_rs, d_uses_rt, d_rs, d_rt, d_dst, d_rwe, d_load, x_branch_taken,
        input  stall_fd, flush_fd, bubble_x, mx_abypass, mx_bbypass, wx_abypass, wx_bbypass,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  d_valid, d_uses_rs, d_uses_rt, d_rs, d_rt, d_dst, d_rwe, d_load, x_branch_taken,
        output stall_fd, flush_fd, bubble_x, mx_abypass, mx_bbypass, wx_abypass, wx_bbypass,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_cmp.sv
// Matches one decode source register against one in-flight scoreboard entry;
// writes to the zero register never create a dependency.
module hazard_cmp
    import pipe_pkg::*;
(
    input  logic             uses_i,
    input  logic             wr_i,
    input  logic [REG_W-1:0] dst_i,
    input  logic [REG_W-1:0] src_i,
    output logic             hit_o
);

    assign hit_o = uses_i & wr_i & (dst_i == src_i) & (dst_i != REG_ZERO);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: X/M/W scoreboard, stall/flush/bubble control and
// bypass selects. Define HAZARD_BYPASS_EN to enable MX/WX bypassing.
module hazard_ctrl
    import pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    hz_state_e   state_q;
    sb_entry_t   x_q, m_q, w_q, x_d;
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic        dv_s, hz_s, stall_s, flush_s, bubble_s, advance_s;
    logic        rs_x_s, rt_x_s, rs_m_s, rt_m_s;
    logic        unused_s;

    hazard_cmp u_cmp_rs_x (.uses_i(bus.d_uses_rs), .wr_i(x_q.wr), .dst_i(x_q.dst), .src_i(bus.d_rs), .hit_o(rs_x_s));
    hazard_cmp u_cmp_rt_x (.uses_i(bus.d_uses_rt), .wr_i(x_q.wr), .dst_i(x_q.dst), .src_i(bus.d_rt), .hit_o(rt_x_s));
    hazard_cmp u_cmp_rs_m (.uses_i(bus.d_uses_rs), .wr_i(m_q.wr), .dst_i(m_q.dst), .src_i(bus.d_rs), .hit_o(rs_m_s));
    hazard_cmp u_cmp_rt_m (.uses_i(bus.d_uses_rt), .wr_i(m_q.wr), .dst_i(m_q.dst), .src_i(bus.d_rt), .hit_o(rt_m_s));

`ifndef HAZARD_BYPASS_EN
    logic rs_w_s, rt_w_s;
    hazard_cmp u_cmp_rs_w (.uses_i(bus.d_uses_rs), .wr_i(w_q.wr), .dst_i(w_q.dst), .src_i(bus.d_rs), .hit_o(rs_w_s));
    hazard_cmp u_cmp_rt_w (.uses_i(bus.d_uses_rt), .wr_i(w_q.wr), .dst_i(w_q.dst), .src_i(bus.d_rt), .hit_o(rt_w_s));
`endif

    // Same-cycle hazard detection; branch wins over stall, reset masks both.
    always_comb begin
        dv_s = bus.d_valid & (state_q != FLUSH);
`ifdef HAZARD_BYPASS_EN
        hz_s = dv_s & x_q.load & (rs_x_s | rt_x_s);
`else
        hz_s = dv_s & (rs_x_s | rt_x_s | rs_m_s | rt_m_s | rs_w_s | rt_w_s);
`endif
        stall_s   = ~rst & ~bus.x_branch_taken & hz_s;
        flush_s   = ~rst & bus.x_branch_taken;
        bubble_s  = rst | bus.x_branch_taken | hz_s | (state_q == FLUSH);
        advance_s = ~bubble_s & dv_s;
        if (advance_s) begin
            x_d = make_entry(1'b1, bus.d_rwe, bus.d_dst, bus.d_load);
        end else begin
            x_d = SB_BUBBLE;
        end
    end

    // Control FSM, scoreboard shift and event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            x_q         <= SB_BUBBLE;
            m_q         <= SB_BUBBLE;
            w_q         <= SB_BUBBLE;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            w_q <= m_q;
            m_q <= x_q;
            x_q <= x_d;
            stall_cnt_q <= stall_cnt_q + {31'd0, stall_s};
            flush_cnt_q <= flush_cnt_q + {31'd0, flush_s};
            if (bus.x_branch_taken) begin
                state_q <= FLUSH;
            end else begin
                case (state_q)
                    RUN, STALL: state_q <= hz_s ? STALL : RUN;
                    FLUSH:      state_q <= RUN;
                    default:    state_q <= RUN;
                endcase
            end
        end
    end

    assign bus.stall_fd  = stall_s;
    assign bus.flush_fd  = flush_s;
    assign bus.bubble_x  = bubble_s;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

`ifdef HAZARD_BYPASS_EN
    logic mx_a_q, mx_b_q, wx_a_q, wx_b_q;

    // Bypass selects captured at the D->X transfer; MX shadows WX per operand.
    always_ff @(posedge clk) begin
        if (rst || !advance_s) begin
            mx_a_q <= 1'b0;
            mx_b_q <= 1'b0;
            wx_a_q <= 1'b0;
            wx_b_q <= 1'b0;
        end else begin
            mx_a_q <= rs_x_s;
            mx_b_q <= rt_x_s;
            wx_a_q <= rs_m_s & ~rs_x_s;
            wx_b_q <= rt_m_s & ~rt_x_s;
        end
    end

    assign bus.mx_abypass = mx_a_q;
    assign bus.mx_bbypass = mx_b_q;
    assign bus.wx_abypass = wx_a_q;
    assign bus.wx_bbypass = wx_b_q;
    assign unused_s = ^{w_q, m_q.load};
`else
    assign bus.mx_abypass = 1'b0;
    assign bus.mx_bbypass = 1'b0;
    assign bus.wx_abypass = 1'b0;
    assign bus.wx_bbypass = 1'b0;
    assign unused_s = ^{w_q.load, m_q.load, x_q.load};
`endif

endmodule
